// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, frame field
// sizes and the default frame start marker.
package boot_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        ADDR      = 3'd1,
        COUNT     = 3'd2,
        PAYLOAD   = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5
    } boot_state_t;

    localparam int          ADDR_BYTES        = 4;
    localparam int          CNT_BYTES         = 2;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    // Little-endian assembly: each new byte enters at the top and earlier bytes
    // drift down, so after four bytes the first one sits in bits [7:0].
    function automatic logic [31:0] shift_in_le(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/byte_accept.sv
// Ready/ack handshake towards the UART receiver: qualifies ready with the
// outstanding ack so that each byte is consumed exactly once.
module byte_accept (
    input  logic clk,
    input  logic reset_n,
    input  logic i_ready,
    output logic o_accept,
    output logic o_ack
);

    logic r_ack;

    assign o_accept = i_ready & ~r_ack;
    assign o_ack    = r_ack;

    // One-cycle ack pulse following every accepted byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= o_accept;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot image parser: SYNC, LE base address, LE word count, LE payload words and
// an XOR checksum; releases the CPU reset only after a fully verified frame.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic        rx_data_ack,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset_n,
    output logic        boot_busy,
    output logic        boot_error
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    boot_state_t   r_state;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_base;
    logic [31:0]   r_waddr;
    logic [31:0]   r_shift;
    logic [15:0]   r_words_left;
    logic [7:0]    r_xor;
    logic [TW-1:0] r_timer;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_cpu_reset_n;
    logic          r_busy;
    logic          r_error;

    logic          w_accept;
    logic          w_in_frame;
    logic [31:0]   w_addr_next;
    logic [31:0]   w_word;
    logic [15:0]   w_cnt_next;

    byte_accept u_byte_accept (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_ready  (rx_data_ready),
        .o_accept (w_accept),
        .o_ack    (rx_data_ack)
    );

    assign w_in_frame  = (r_state == ADDR) || (r_state == COUNT) ||
                         (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_addr_next = shift_in_le(r_base, rx_data);
    assign w_word      = shift_in_le(r_shift, rx_data);
    assign w_cnt_next  = {rx_data, r_words_left[15:8]};

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_reset_n = r_cpu_reset_n;
    assign boot_busy   = r_busy;
    assign boot_error  = r_error;

    // Frame FSM with byte assembly, write strobe and inter-byte timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_SYNC;
            r_byte_idx    <= 2'd0;
            r_base        <= 32'd0;
            r_waddr       <= 32'd0;
            r_shift       <= 32'd0;
            r_words_left  <= 16'd0;
            r_xor         <= 8'd0;
            r_timer       <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                r_timer <= '0;
                case (r_state)
                    WAIT_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_state    <= ADDR;
                            r_byte_idx <= 2'd0;
                            r_xor      <= 8'd0;
                            r_error    <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                    ADDR: begin
                        r_xor      <= r_xor ^ rx_data;
                        r_base     <= w_addr_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'(ADDR_BYTES - 1)) begin
                            r_byte_idx <= 2'd0;
                            if (w_addr_next[1:0] != 2'b00) begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= WAIT_SYNC;
                            end else begin
                                r_state <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        r_xor        <= r_xor ^ rx_data;
                        r_words_left <= w_cnt_next;
                        r_byte_idx   <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'(CNT_BYTES - 1)) begin
                            r_byte_idx <= 2'd0;
                            r_waddr    <= r_base;
                            r_state    <= (w_cnt_next == 16'd0) ? CHECK : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        r_xor      <= r_xor ^ rx_data;
                        r_shift    <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_waddr;
                            r_mem_wdata  <= w_word;
                            r_waddr      <= r_waddr + 32'd4;
                            r_words_left <= r_words_left - 16'd1;
                            if (r_words_left == 16'd1) begin
                                r_state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        r_busy <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_cpu_reset_n <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= WAIT_SYNC;
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= WAIT_SYNC;
                    end
                endcase
            end else if (w_in_frame) begin
                // A stalled host abandons the frame; any partial word is dropped.
                if (r_timer == TIMEOUT_LAST) begin
                    r_timer    <= '0;
                    r_byte_idx <= 2'd0;
                    r_error    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= WAIT_SYNC;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

endmodule
